// File: rtl/team_06_noise_gate.sv
// Envelope-following noise gate: peak envelope tracker, attack/hold/release gain FSM
// and a two-stage gain multiplier for 8-bit offset-binary audio.
module team_06_noise_gate #(
    parameter int OPEN_THRESH  = 24,
    parameter int CLOSE_THRESH = 16,
    parameter int HOLD_SAMPLES = 2000,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 1,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic [7:0] audio_in,
    output logic [7:0] audio_out,
    output logic       out_valid,
    output logic       gate_open,
    output logic [8:0] gain
);

    localparam int STAGES = 2;

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [7:0]  OPEN_T    = 8'(OPEN_THRESH);
    localparam logic [7:0]  CLOSE_T   = 8'(CLOSE_THRESH);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_SAMPLES - 1);
    localparam logic [9:0]  ATK_S     = 10'(ATTACK_STEP);
    localparam logic [8:0]  REL_S     = 9'(RELEASE_STEP);

    logic [STAGES-1:0] vld_pipe_q;
    logic [2:0]        state_q, state_d;
    logic [8:0]        gain_q, gain_d;
    logic [15:0]       hold_q, hold_d;
    logic [7:0]        env_q;
    logic signed [8:0] d_q;
    logic [7:0]        audio_out_q;

    // Stage 1: signed sample, magnitude and decayed envelope
    logic signed [8:0] d;
    logic [7:0]        mag, env_shr, env_dec, env_n;

    always_comb begin
        d       = $signed({1'b0, audio_in}) - 9'sd128;
        mag     = d[8] ? 8'(-d) : 8'(d);
        env_shr = env_q >> DECAY_SHIFT;
        if (env_q == 8'd0)
            env_dec = 8'd0;
        else if (env_shr == 8'd0)
            env_dec = env_q - 8'd1;
        else
            env_dec = env_q - env_shr;
        env_n = (mag > env_dec) ? mag : env_dec;
    end

    // Saturating gain ramps; both candidates are computed every sample
    logic [9:0] gsum;
    logic [8:0] gain_a, gain_r;
    logic       a_full, open_hit, close_hit;

    always_comb begin
        gsum      = {1'b0, gain_q} + ATK_S;
        a_full    = (gsum >= 10'd256);
        gain_a    = a_full ? 9'd256 : gsum[8:0];
        gain_r    = (gain_q > REL_S) ? (gain_q - REL_S) : 9'd0;
        open_hit  = (env_n >= OPEN_T);
        close_hit = (env_n < CLOSE_T);
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        if (!enable) begin
            state_d = S_OPEN;
            gain_d  = 9'd256;
        end else begin
            case (state_q)
                S_CLOSED: begin
                    if (open_hit) begin
                        gain_d  = gain_a;
                        state_d = a_full ? S_OPEN : S_ATTACK;
                    end
                end
                S_ATTACK: begin
                    if (close_hit) begin
                        state_d = S_RELEASE;
                        gain_d  = gain_r;
                    end else begin
                        gain_d = gain_a;
                        if (a_full) state_d = S_OPEN;
                    end
                end
                S_OPEN: begin
                    gain_d = 9'd256;
                    if (close_hit) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end
                S_HOLD: begin
                    if (open_hit) begin
                        state_d = S_OPEN;
                    end else if (hold_q == 16'd0) begin
                        state_d = S_RELEASE;
                        gain_d  = gain_r;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (open_hit) begin
                        gain_d  = gain_a;
                        state_d = a_full ? S_OPEN : S_ATTACK;
                    end else begin
                        gain_d = gain_r;
                        if (gain_r == 9'd0) state_d = S_CLOSED;
                    end
                end
                default: begin
                    state_d = S_CLOSED;
                    gain_d  = 9'd0;
                end
            endcase
        end
    end

    // Stage 2: gain_q already holds this sample's gain; floor shift keeps 0..255
    logic signed [17:0] d_ext, g_ext, prod;
    logic [7:0]         scaled, out_d;

    always_comb begin
        d_ext  = {{9{d_q[8]}}, d_q};
        g_ext  = {9'd0, gain_q};
        prod   = d_ext * g_ext;
        scaled = 8'(prod >>> 8);
        out_d  = {~scaled[7], scaled[6:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            state_q     <= S_CLOSED;
            gain_q      <= 9'd0;
            hold_q      <= 16'd0;
            env_q       <= 8'd0;
            d_q         <= 9'sd0;
            audio_out_q <= 8'd128;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], sample_valid};
            if (sample_valid) begin
                state_q <= state_d;
                gain_q  <= gain_d;
                hold_q  <= hold_d;
                env_q   <= env_n;
                d_q     <= d;
            end
            if (vld_pipe_q[0]) audio_out_q <= out_d;
        end
    end

    assign audio_out = audio_out_q;
    assign out_valid = vld_pipe_q[STAGES-1];
    assign gate_open = (state_q != S_CLOSED);
    assign gain      = gain_q;

endmodule

// File: tb/tb_team_06_noise_gate.sv
// Bench for team_06_noise_gate: directed literal scenarios plus randomized traffic
// compared every cycle against a sample-level reference model.
module tb_team_06_noise_gate;

    localparam int OPEN_T = 24;
    localparam int CLOSE_T = 16;
    localparam int HOLD_N = 4;
    localparam int ATK = 32;
    localparam int REL = 64;
    localparam int DS = 4;

    localparam int M_CLOSED = 0;
    localparam int M_ATTACK = 1;
    localparam int M_OPEN = 2;
    localparam int M_HOLD = 3;
    localparam int M_RELEASE = 4;

    logic       clk = 1'b0;
    logic       rst, enable, sample_valid;
    logic [7:0] audio_in;
    logic [7:0] audio_out;
    logic       out_valid, gate_open;
    logic [8:0] gain;

    always #5 clk = ~clk;

    team_06_noise_gate #(
        .OPEN_THRESH(OPEN_T), .CLOSE_THRESH(CLOSE_T), .HOLD_SAMPLES(HOLD_N),
        .ATTACK_STEP(ATK), .RELEASE_STEP(REL), .DECAY_SHIFT(DS)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .audio_in(audio_in), .audio_out(audio_out), .out_valid(out_valid),
        .gate_open(gate_open), .gain(gain)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per accepted sample, integer arithmetic only
    int m_env = 0, m_gain = 0, m_st = M_CLOSED, m_hold = 0;
    int cyc = 0, last_out = 128;
    int q_due[$];
    int q_val[$];

    function automatic int floor_div256(int p);
        int q;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        return q;
    endfunction

    task automatic model_sample(int x, bit en, output int o);
        int d, mag, dec, s, envn, a, r;
        d = x - 128;
        mag = (d < 0) ? -d : d;
        if (m_env == 0) dec = 0;
        else begin
            s = m_env / (1 << DS);
            if (s < 1) s = 1;
            dec = m_env - s;
        end
        envn = (mag > dec) ? mag : dec;
        m_env = envn;
        a = (m_gain + ATK > 256) ? 256 : m_gain + ATK;
        r = (m_gain - REL < 0) ? 0 : m_gain - REL;
        if (!en) begin
            m_st = M_OPEN;
            m_gain = 256;
        end else if (m_st == M_OPEN) begin
            m_gain = 256;
            if (envn < CLOSE_T) begin m_st = M_HOLD; m_hold = HOLD_N - 1; end
        end else if (m_st == M_HOLD) begin
            if (envn >= OPEN_T) m_st = M_OPEN;
            else if (m_hold == 0) begin m_st = M_RELEASE; m_gain = r; end
            else m_hold = m_hold - 1;
        end else if (m_st == M_ATTACK && envn < CLOSE_T) begin
            m_st = M_RELEASE;
            m_gain = r;
        end else if (m_st == M_ATTACK || envn >= OPEN_T) begin
            m_gain = a;
            m_st = (a == 256) ? M_OPEN : M_ATTACK;
        end else if (m_st == M_RELEASE) begin
            m_gain = r;
            if (r == 0) m_st = M_CLOSED;
        end
        o = 128 + floor_div256(d * m_gain);
    endtask

    always @(posedge clk) begin
        int o;
        cyc++;
        if (rst) begin
            m_env = 0; m_gain = 0; m_st = M_CLOSED; m_hold = 0;
            q_due.delete(); q_val.delete();
            last_out = 128;
        end else if (sample_valid) begin
            model_sample(int'(audio_in), enable, o);
            q_due.push_back(cyc + 1);
            q_val.push_back(o);
        end
    end

    always @(negedge clk) begin
        int ev;
        if (chk_en) begin
            ev = 0;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                ev = 1;
                last_out = q_val[0];
                void'(q_due.pop_front());
                void'(q_val.pop_front());
            end
            chk("model out_valid", int'(out_valid), ev);
            chk("model audio_out", int'(audio_out), last_out);
            chk("model gain", int'(gain), m_gain);
            chk("model gate_open", int'(gate_open), int'(m_st != M_CLOSED));
        end
    end

    task automatic step(bit r, bit v, bit en, int x);
        rst = r;
        sample_valid = v;
        enable = en;
        audio_in = 8'(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit loud;
        rst = 1'b1; sample_valid = 1'b1; enable = 1'b1; audio_in = 8'd200;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        // Reset held with samples strobing
        chk("reset audio_out", int'(audio_out), 128);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset gate_open", int'(gate_open), 0);
        chk("reset gain", int'(gain), 0);

        // Bypass is bit-exact at two-cycle latency
        step(0, 1, 0, 0);
        step(0, 1, 0, 255);
        chk("bypass out0", int'(audio_out), 0);
        chk("bypass vld0", int'(out_valid), 1);
        step(0, 1, 0, 77);
        chk("bypass out1", int'(audio_out), 255);
        step(0, 0, 1, 128);
        chk("bypass out2", int'(audio_out), 77);
        step(0, 0, 1, 128);
        chk("bypass vld end", int'(out_valid), 0);

        // Below threshold from a freshly reset gate
        step(1, 1, 1, 200);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 140);
        chk("quiet audio_out", int'(audio_out), 128);
        chk("quiet gate_open", int'(gate_open), 0);
        chk("quiet gain", int'(gain), 0);

        // Attack ramp
        step(0, 1, 1, 200);
        chk("attack gain1", int'(gain), 32);
        for (int i = 2; i <= 8; i++) begin
            step(0, 1, 1, 200);
            chk("attack gain ramp", int'(gain), 32 * i);
            if (i == 2) chk("attack first out", int'(audio_out), 137);
        end
        step(0, 1, 1, 200);
        chk("open out", int'(audio_out), 200);
        chk("open gate", int'(gate_open), 1);

        // Hold then release on silence; env 72 decays below 16 on the 31st sample
        n = 0;
        do begin step(0, 1, 1, 128); n++; end while (gain == 9'd256 && n < 200);
        chk("release sample index", n, 35);
        chk("release gain1", int'(gain), 192);
        step(0, 1, 1, 128);
        chk("release gain2", int'(gain), 128);
        step(0, 1, 1, 128);
        chk("release gain3", int'(gain), 64);
        chk("release gate still open", int'(gate_open), 1);
        step(0, 1, 1, 128);
        chk("release gain4", int'(gain), 0);
        chk("closed gate", int'(gate_open), 0);

        // Reset in the middle of a release
        for (int i = 0; i < 8; i++) step(0, 1, 1, 200);
        n = 0;
        do begin step(0, 1, 1, 128); n++; end while (gain == 9'd256 && n < 200);
        step(0, 1, 1, 128);
        chk("pre-reset gain", int'(gain), 128);
        step(1, 1, 1, 200);
        chk("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset audio_out", int'(audio_out), 128);
        chk("mid reset gain", int'(gain), 0);
        chk("mid reset gate", int'(gate_open), 0);
        step(0, 1, 1, 200);
        chk("restart gain", int'(gain), 32);

        // Randomized traffic with loud/quiet bursts
        loud = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 48) == 0) loud = ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 24) != 0),
                 loud ? int'($urandom_range(0, 255)) : 118 + int'($urandom_range(0, 20)));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 128);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
